imem_loadable: RTL and testbench

Parametrised, synchronous-read instruction memory for the pipelined MIPS core, replacing the fixed combinational instruction ROM. Holds a program of up to 2^ADDR_WIDTH words. The program is streamed in through a valid/ready load port, and the core is held off via `core_hold` while loading. The fetch port returns one word per cycle with one-cycle latency and supports pipeline stalls.

---
 rtl/imem_loadable.sv | 131 +++++++++++++
 tb/tb_imem_loadable.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Loadable synchronous-read instruction memory. A program is streamed in over
// a valid/ready port while core_hold keeps the core in reset; the fetch port
// returns one word per cycle with one cycle of latency and honours stalls.
module imem_loadable #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  fetch_hold,
  input  logic [31:0]           fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  output logic                  fetch_fault,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  core_hold,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_SAT   = CNT_DEPTH + CNT_ONE;

  typedef enum logic [1:0] {RUN, LOAD, FINISH} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;

  logic                  handshake;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  addr_fault;

  assign load_ready  = (state_q == LOAD);
  assign core_hold   = (state_q != RUN);
  assign load_done   = (state_q == FINISH);
  assign load_count  = count_q;
  assign load_error  = error_q;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;

  assign handshake  = load_valid && load_ready;
  assign in_range   = (count_q < CNT_DEPTH);
  assign mem_we     = handshake && in_range;
  assign fetch_idx  = fetch_addr[ADDR_WIDTH+1:2];
  assign addr_fault = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[31:ADDR_WIDTH+2]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (load_start) state_d = LOAD;
      LOAD:    if (handshake && load_last) state_d = FINISH;
      FINISH:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Count saturates one past depth so an overflow stays visible without wrapping.
  always_comb begin
    count_d = count_q;
    error_d = error_q;
    if ((state_q == RUN) && load_start) begin
      count_d = '0;
      error_d = 1'b0;
    end else if (handshake) begin
      if (!in_range) error_d = 1'b1;
      if (count_q != CNT_SAT) count_d = count_q + CNT_ONE;
    end
  end

  // Outputs are registered, so a fetch accepted on the RUN->LOAD edge still
  // shows up in the first LOAD cycle; blocking takes effect from then on.
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (state_q != RUN) begin
      instr_d = FILL_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (!fetch_hold) begin
      if (fetch_en) begin
        valid_d = 1'b1;
        fault_d = addr_fault;
        instr_d = addr_fault ? FILL_WORD : mem[fetch_idx];
      end else begin
        valid_d = 1'b0;
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      instr_q <= FILL_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[ADDR_WIDTH-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ADDR_WIDTH=8 instance
  logic        reset, fetch_en, fetch_hold, load_start, load_valid, load_last;
  logic [31:0] fetch_addr, load_data, instruction;
  logic        inst_valid, fetch_fault, load_ready, core_hold, load_done, load_error;
  logic [8:0]  load_count;

  // ADDR_WIDTH=2 instance
  logic        reset2, fetch_en2, fetch_hold2, load_start2, load_valid2, load_last2;
  logic [31:0] fetch_addr2, load_data2, instruction2;
  logic        inst_valid2, fetch_fault2, load_ready2, core_hold2, load_done2, load_error2;
  logic [2:0]  load_count2;

  imem_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FILL_WORD(32'h0)) dut8 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_hold(fetch_hold),
    .fetch_addr(fetch_addr), .instruction(instruction), .inst_valid(inst_valid),
    .fetch_fault(fetch_fault), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .core_hold(core_hold), .load_count(load_count), .load_done(load_done),
    .load_error(load_error)
  );

  imem_loadable #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .FILL_WORD(32'h0)) dut2 (
    .clk(clk), .reset(reset2), .fetch_en(fetch_en2), .fetch_hold(fetch_hold2),
    .fetch_addr(fetch_addr2), .instruction(instruction2), .inst_valid(inst_valid2),
    .fetch_fault(fetch_fault2), .load_start(load_start2), .load_valid(load_valid2),
    .load_data(load_data2), .load_last(load_last2), .load_ready(load_ready2),
    .core_hold(core_hold2), .load_count(load_count2), .load_done(load_done2),
    .load_error(load_error2)
  );

  // Reference model: memory image as the program loader sees it.
  logic [31:0] model_mem [256];
  int unsigned known = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    fetch_en = 0; fetch_hold = 0; load_start = 0; load_valid = 0; load_last = 0;
  endtask

  task automatic test_reset();
    reset = 1; reset2 = 1; idle8(); fetch_addr = 0; load_data = 0;
    fetch_en2 = 0; fetch_hold2 = 0; load_start2 = 0; load_valid2 = 0; load_last2 = 0;
    fetch_addr2 = 0; load_data2 = 0;
    step(); step();
    checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instruction); end
    checks++; if ({inst_valid, fetch_fault} !== 2'b00) begin failures++; $display("FAIL rst_valid_fault got=%b%b exp=00", inst_valid, fetch_fault); end
    checks++; if ({load_ready, core_hold, load_done, load_error} !== 4'b0) begin failures++; $display("FAIL rst_load_flags got=%b%b%b%b exp=0000", load_ready, core_hold, load_done, load_error); end
    checks++; if (load_count !== 9'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", load_count); end
    checks++; if ({core_hold2, load_count2} !== 4'b0) begin failures++; $display("FAIL rst2 got=%b %0d exp=0 0", core_hold2, load_count2); end
    reset = 0; reset2 = 0;
    step();
  endtask

  task automatic test_load_program();
    logic [31:0] prog [3];
    prog[0] = 32'h3c010040; prog[1] = 32'h343f0018; prog[2] = 32'h03e00008;
    load_start = 1; step(); load_start = 0;
    checks++; if ({core_hold, load_ready} !== 2'b11) begin failures++; $display("FAIL load_enter got=%b%b exp=11", core_hold, load_ready); end
    checks++; if (load_count !== 9'd0) begin failures++; $display("FAIL load_count0 got=%0d exp=0", load_count); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = prog[i]; load_last = (i == 2);
      step();
      model_mem[i] = prog[i];
      checks++; if (load_count !== 9'(i + 1)) begin failures++; $display("FAIL load_count got=%0d exp=%0d", load_count, i + 1); end
      checks++; if (load_done !== (i == 2)) begin failures++; $display("FAIL load_done_pulse got=%b exp=%b", load_done, (i == 2)); end
    end
    known = 3;
    checks++; if ({load_ready, core_hold} !== 2'b01) begin failures++; $display("FAIL finish_flags got=%b%b exp=01", load_ready, core_hold); end
    load_valid = 0; load_last = 0;
    step();
    checks++; if ({load_done, core_hold} !== 2'b00) begin failures++; $display("FAIL after_finish got=%b%b exp=00", load_done, core_hold); end
  endtask

  task automatic test_fetch_seq();
    fetch_en = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(i * 4);
      step();
      checks++; if ({inst_valid, instruction} !== {1'b1, model_mem[i]}) begin failures++; $display("FAIL seq_fetch%0d got=%b %h exp=1 %h", i, inst_valid, instruction, model_mem[i]); end
    end
    fetch_en = 0; step();
    checks++; if ({inst_valid, fetch_fault, instruction} !== {2'b00, model_mem[2]}) begin failures++; $display("FAIL seq_idle got=%b%b %h exp=00 %h", inst_valid, fetch_fault, instruction, model_mem[2]); end
  endtask

  task automatic test_stall();
    fetch_en = 1; fetch_addr = 32'h4; step();
    checks++; if (instruction !== 32'h343f0018) begin failures++; $display("FAIL stall_pre got=%h exp=343f0018", instruction); end
    fetch_hold = 1; fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({inst_valid, instruction} !== {1'b1, 32'h343f0018}) begin failures++; $display("FAIL stall_hold%0d got=%b %h exp=1 343f0018", i, inst_valid, instruction); end
    end
    fetch_hold = 0; step();
    checks++; if ({inst_valid, instruction} !== {1'b1, 32'h03e00008}) begin failures++; $display("FAIL stall_release got=%b %h exp=1 03e00008", inst_valid, instruction); end
    fetch_en = 0; step();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4];
    logic        flt   [4];
    addrs[0] = 32'h6;   flt[0] = 1;
    addrs[1] = 32'h400; flt[1] = 1;
    addrs[2] = 32'h3fc; flt[2] = 0;
    addrs[3] = 32'h80000000; flt[3] = 1;
    fetch_en = 1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = addrs[i]; step();
      checks++; if ({inst_valid, fetch_fault} !== {1'b1, flt[i]}) begin failures++; $display("FAIL fault_flag@%h got=%b%b exp=1%b", addrs[i], inst_valid, fetch_fault, flt[i]); end
      if (flt[i]) begin
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL fault_fill@%h got=%h exp=0", addrs[i], instruction); end
      end
    end
    fetch_en = 0; step();
    checks++; if ({inst_valid, fetch_fault} !== 2'b00) begin failures++; $display("FAIL fault_clear got=%b%b exp=00", inst_valid, fetch_fault); end
  endtask

  task automatic test_same_cycle_load();
    logic [31:0] w;
    fetch_en = 1; fetch_addr = 32'h4; load_start = 1; step(); load_start = 0;
    checks++; if ({core_hold, inst_valid, instruction} !== {2'b11, model_mem[1]}) begin failures++; $display("FAIL same_cycle got=%b%b %h exp=11 %h", core_hold, inst_valid, instruction, model_mem[1]); end
    step();
    checks++; if ({inst_valid, instruction} !== {1'b0, 32'h0}) begin failures++; $display("FAIL blocked_in_load got=%b %h exp=0 0", inst_valid, instruction); end
    w = $urandom;
    load_valid = 1; load_data = w; load_last = 1; step();
    model_mem[0] = w;
    load_valid = 0; load_last = 0; fetch_addr = 32'h0;
    checks++; if ({load_done, inst_valid} !== 2'b10) begin failures++; $display("FAIL one_word_finish got=%b%b exp=10", load_done, inst_valid); end
    step();
    checks++; if ({core_hold, inst_valid} !== 2'b00) begin failures++; $display("FAIL finish_blocked got=%b%b exp=00", core_hold, inst_valid); end
    step();
    checks++; if ({inst_valid, instruction} !== {1'b1, w}) begin failures++; $display("FAIL load_to_fetch got=%b %h exp=1 %h", inst_valid, instruction, w); end
    fetch_en = 0; step();
  endtask

  task automatic test_overflow();
    logic [31:0] w [5];
    load_start2 = 1; step(); load_start2 = 0;
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      load_valid2 = 1; load_data2 = w[i]; load_last2 = (i == 4);
      checks++; if ({load_ready2, core_hold2} !== 2'b11) begin failures++; $display("FAIL ovf_ready%0d got=%b%b exp=11", i, load_ready2, core_hold2); end
      step();
      checks++; if ({load_count2, load_error2, load_done2} !== {3'(i + 1), (i == 4), (i == 4)}) begin failures++; $display("FAIL ovf_hs%0d got=%0d %b %b exp=%0d %b %b", i, load_count2, load_error2, load_done2, i + 1, (i == 4), (i == 4)); end
    end
    load_valid2 = 0; load_last2 = 0; step();
    fetch_en2 = 1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr2 = 32'(i * 4); step();
      checks++; if ({inst_valid2, fetch_fault2, instruction2} !== {2'b10, w[i]}) begin failures++; $display("FAIL ovf_word%0d got=%b%b %h exp=10 %h", i, inst_valid2, fetch_fault2, instruction2, w[i]); end
    end
    fetch_addr2 = 32'h10; step();
    checks++; if ({fetch_fault2, instruction2} !== {1'b1, 32'h0}) begin failures++; $display("FAIL ovf_range got=%b %h exp=1 0", fetch_fault2, instruction2); end
    checks++; if (load_error2 !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", load_error2); end
    fetch_en2 = 0; load_start2 = 1; step(); load_start2 = 0;
    checks++; if ({load_error2, load_count2} !== 4'b0) begin failures++; $display("FAIL ovf_restart got=%b %0d exp=0 0", load_error2, load_count2); end
    load_valid2 = 1; load_data2 = w[0]; load_last2 = 1; step();
    load_valid2 = 0; load_last2 = 0; step();
  endtask

  task automatic test_random();
    int unsigned n, i, cyc, idx, r;
    logic        exp_valid, exp_fault, en, hold;
    logic [31:0] exp_instr, a;
    n = $urandom_range(4, 40);
    load_start = 1; step(); load_start = 0;
    i = 0; cyc = 0;
    while (i < n && cyc < 1000) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = $urandom;
      load_last  = load_valid && (i == n - 1);
      step(); cyc++;
      if (load_valid) begin model_mem[i] = load_data; i++; end
    end
    checks++; if (i != n) begin failures++; $display("FAIL rnd_load_budget got=%0d exp=%0d", i, n); end
    load_valid = 0; load_last = 0;
    checks++; if ({load_done, load_count} !== {1'b1, 9'(n)}) begin failures++; $display("FAIL rnd_load_end got=%b %0d exp=1 %0d", load_done, load_count, n); end
    if (n > known) known = n;
    step();
    exp_instr = 32'h0; exp_valid = 0; exp_fault = 0;
    for (int c = 0; c < 300; c++) begin
      en = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      idx = $urandom_range(0, known - 1);
      if (r < 7)       a = 32'(idx * 4);
      else if (r == 7) a = 32'(idx * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
      else             a = $urandom | 32'h8000_0000;
      fetch_en = en; fetch_hold = hold; fetch_addr = a;
      if (!hold) begin
        if (en) begin
          exp_valid = 1;
          exp_fault = (a % 4 != 0) || (a >= 32'h400);
          exp_instr = exp_fault ? 32'h0 : model_mem[a / 4];
        end else begin
          exp_valid = 0; exp_fault = 0;
        end
      end
      step();
      checks++; if ({inst_valid, fetch_fault} !== {exp_valid, exp_fault}) begin failures++; $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b", c, inst_valid, fetch_fault, exp_valid, exp_fault); end
      checks++; if (instruction !== exp_instr) begin failures++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, instruction, exp_instr); end
    end
    idle8(); step();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    load_start = 1; step(); load_start = 0;
    load_valid = 1; load_data = w0; step();
    load_data = w1; step();
    model_mem[0] = w0; model_mem[1] = w1;
    load_valid = 0; reset = 1; step();
    checks++; if ({core_hold, load_ready, load_done, load_error, inst_valid} !== 5'b0) begin failures++; $display("FAIL midrst_flags got=%b%b%b%b%b exp=00000", core_hold, load_ready, load_done, load_error, inst_valid); end
    checks++; if (load_count !== 9'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", load_count); end
    reset = 0; step();
    checks++; if ({load_done, core_hold} !== 2'b00) begin failures++; $display("FAIL midrst_nodone got=%b%b exp=00", load_done, core_hold); end
    fetch_en = 1; fetch_addr = 32'h4; step();
    checks++; if ({inst_valid, instruction} !== {1'b1, w1}) begin failures++; $display("FAIL midrst_word got=%b %h exp=1 %h", inst_valid, instruction, w1); end
    fetch_en = 0; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_program();
    test_fetch_seq();
    test_stall();
    test_faults();
    test_same_cycle_load();
    test_overflow();
    test_random();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
